// File: rtl/apb_slave_mem.sv
// APB3 word-addressed RAM slave with programmable wait states, PSLVERR on out-of-range access.
// Optional byte strobes: define APB_SLV_PSTRB_EN to add the i_pstrb port.
module apb_slave_mem #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic                  i_pclk,
    input  logic                  i_preset,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_W-1:0]     i_paddr,
    input  logic [DATA_W-1:0]     i_pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0]   i_pstrb,
`endif
    output logic [DATA_W-1:0]     o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr
);
    localparam int unsigned NBYTES    = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(NBYTES);
    localparam int unsigned IDX_W     = ADDR_W - OFF_W;
    localparam int unsigned MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e              r_state, w_state_d;
    logic [3:0]          r_cnt;
    logic [MEM_AW-1:0]   r_addr;
    logic                r_write;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic                w_oor;
    logic                w_setup;
    logic                w_done;
    logic                w_wr_en;
    logic [NBYTES-1:0]   w_be;
    logic                w_unused_addr;

    assign w_idx         = i_paddr[ADDR_W-1:OFF_W];
    assign w_oor         = (32'(w_idx) >= DEPTH);
    assign w_unused_addr = ^i_paddr;
    assign w_setup       = (r_state == StIdle) && i_psel && !i_penable;
    assign w_done        = (r_state == StAccess) && i_psel && i_penable && o_pready;
    // Reset on the completion edge wins: the pending write is dropped.
    assign w_wr_en       = w_done && r_write && !r_err && !i_preset;

`ifdef APB_SLV_PSTRB_EN
    assign w_be = i_pstrb;
`else
    assign w_be = '1;
`endif

    assign o_pready  = (r_state == StAccess) && (r_cnt == WAIT_LAST);
    assign o_pslverr = o_pready && r_err;
    assign o_prdata  = (o_pready && !r_err) ? r_rdata : '0;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (w_setup) w_state_d = StAccess;
            StAccess: if (!i_psel || w_done) w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_setup) begin
                r_cnt   <= '0;
                r_addr  <= w_idx[MEM_AW-1:0];
                r_write <= i_pwrite;
                r_err   <= w_oor;
                r_rdata <= w_oor ? '0 : r_mem[w_idx[MEM_AW-1:0]];
            end else if (r_state == StAccess && r_cnt != WAIT_LAST) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge i_pclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_be[b]) r_mem[r_addr][8*b +: 8] <= i_pwdata[8*b +: 8];
            end
        end
    end

endmodule
